// File: rtl/register_file_pkg.sv
// Shared sizing constants and the per-port lookup result for the rename register file.
package register_file_pkg;
  localparam int REG_NUM        = 32;
  localparam int REGISTER_WIDTH = 5;
  localparam int ROB_WIDTH      = 4;
  localparam int DATA_W         = 32;
  localparam logic [ROB_WIDTH-1:0] NULL_TAG = '0;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic                 busy;
    logic [ROB_WIDTH-1:0] tag;
  } rf_entry_t;
endpackage

// File: rtl/register_file_read_port.sv
// One source-operand lookup: indexes the storage and forwards a same-cycle matching commit.
module regfile_read_port
  import register_file_pkg::*;
(
  input  logic [REGISTER_WIDTH-1:0] rs_i,
  input  logic [DATA_W-1:0]         reg_data_i,
  input  logic                      reg_busy_i,
  input  logic [ROB_WIDTH-1:0]      reg_tag_i,
  input  logic                      commit_vld_i,
  input  logic [REGISTER_WIDTH-1:0] commit_rd_i,
  input  logic [ROB_WIDTH-1:0]      commit_tag_i,
  input  logic [DATA_W-1:0]         commit_data_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      busy_o,
  output logic [ROB_WIDTH-1:0]      tag_o
);
  logic bypass;

  // Forward only when the committing tag is still the live producer of rs.
  assign bypass = commit_vld_i && (commit_rd_i == rs_i) && reg_busy_i &&
                  (reg_tag_i == commit_tag_i);

  always_comb begin
    data_o = reg_data_i;
    busy_o = reg_busy_i;
    tag_o  = reg_tag_i;
    if (rs_i == '0) begin
      data_o = '0;
      busy_o = 1'b0;
      tag_o  = NULL_TAG;
    end else if (bypass) begin
      data_o = commit_data_i;
      busy_o = 1'b0;
      tag_o  = NULL_TAG;
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags: two bypassed read ports, rename, commit and flush.
module register_file
  import register_file_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dispatcher_en_in,
  input  logic [REGISTER_WIDTH-1:0] dispatcher_rs1_in,
  input  logic [REGISTER_WIDTH-1:0] dispatcher_rs2_in,
  input  logic [REGISTER_WIDTH-1:0] dispatcher_rd_in,
  input  logic [ROB_WIDTH-1:0]      dispatcher_rd_robnum_in,
  output logic [DATA_W-1:0]         rs1_data_out,
  output logic                      rs1_busy_out,
  output logic [ROB_WIDTH-1:0]      rs1_robnum_out,
  output logic [DATA_W-1:0]         rs2_data_out,
  output logic                      rs2_busy_out,
  output logic [ROB_WIDTH-1:0]      rs2_robnum_out,
  input  logic                      rob_commit_en_in,
  input  logic [REGISTER_WIDTH-1:0] rob_commit_rd_in,
  input  logic [ROB_WIDTH-1:0]      rob_commit_robnum_in,
  input  logic [DATA_W-1:0]         rob_commit_data_in,
  input  logic                      rob_clear_in
);
  logic [DATA_W-1:0]    data_q [REG_NUM];
  logic [DATA_W-1:0]    data_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q, busy_d;
  logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d  [REG_NUM];
  logic                 commit_vld;
  logic                 commit_hit;

  assign commit_vld = rob_commit_en_in && rdy_in;
  assign commit_hit = busy_q[rob_commit_rd_in] &&
                      (tag_q[rob_commit_rd_in] == rob_commit_robnum_in);

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (rob_commit_en_in && rob_commit_rd_in != '0) begin
        data_d[rob_commit_rd_in] = rob_commit_data_in;
        if (commit_hit) begin
          busy_d[rob_commit_rd_in] = 1'b0;
          tag_d[rob_commit_rd_in]  = NULL_TAG;
        end
      end
      // Flush discards every rename, including one arriving this cycle; rename otherwise beats commit.
      if (rob_clear_in) begin
        busy_d = '0;
        for (int i = 0; i < REG_NUM; i++) tag_d[i] = NULL_TAG;
      end else if (dispatcher_en_in && dispatcher_rd_in != '0) begin
        busy_d[dispatcher_rd_in] = 1'b1;
        tag_d[dispatcher_rd_in]  = dispatcher_rd_robnum_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= NULL_TAG;
      end
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  regfile_read_port u_rs1 (
    .rs_i          (dispatcher_rs1_in),
    .reg_data_i    (data_q[dispatcher_rs1_in]),
    .reg_busy_i    (busy_q[dispatcher_rs1_in]),
    .reg_tag_i     (tag_q[dispatcher_rs1_in]),
    .commit_vld_i  (commit_vld),
    .commit_rd_i   (rob_commit_rd_in),
    .commit_tag_i  (rob_commit_robnum_in),
    .commit_data_i (rob_commit_data_in),
    .data_o        (rs1_data_out),
    .busy_o        (rs1_busy_out),
    .tag_o         (rs1_robnum_out)
  );

  regfile_read_port u_rs2 (
    .rs_i          (dispatcher_rs2_in),
    .reg_data_i    (data_q[dispatcher_rs2_in]),
    .reg_busy_i    (busy_q[dispatcher_rs2_in]),
    .reg_tag_i     (tag_q[dispatcher_rs2_in]),
    .commit_vld_i  (commit_vld),
    .commit_rd_i   (rob_commit_rd_in),
    .commit_tag_i  (rob_commit_robnum_in),
    .commit_data_i (rob_commit_data_in),
    .data_o        (rs2_data_out),
    .busy_o        (rs2_busy_out),
    .tag_o         (rs2_robnum_out)
  );
endmodule
